btc_job_ctrl: RTL and testbench
===============================

# btc_job_ctrl

Job sequencer in front of the byte-serial hashing core (`tt_um_bitcoin`). Holds one 76-byte header prefix and a difficulty, then repeatedly starts the core. For each attempt it feeds 76 prefix bytes plus a 4-byte nonce over the core's rq/rdy handshake and drains the 32-byte hash. Each hash is scored by leading-zero bits; the block stops on a hit, on nonce exhaustion, or on a host stop request.

## Interface
- `HDR_BYTES`, 76: prefix bytes fed before the nonce.
- `HASH_BYTES`, 32: hash bytes drained per attempt.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: config byte write strobe; ignored while `busy`.
- `cfg_addr` in 7: 0..75 prefix byte; 76..79 start nonce (76 = MSB); 80 difficulty; 81..127 ignored.
- `cfg_data` in 8: config write data.
- `go` in 1: one-cycle pulse; starts the search when idle, ignored while `busy`.
- `stop` in 1: one-cycle pulse; requests a halt after the current attempt.
- `busy` out 1: high from the cycle after accepted `go` until return to IDLE.
- `found` out 1: sticky; set on a hit, cleared by the next accepted `go`.
- `exhausted` out 1: sticky; set when nonce 0xFFFFFFFF fails, cleared by `go`.
- `found_nonce` out 32: nonce of the hit; valid while `found`.
- `core_start` out 1: core start, to `uio_in[0]`.
- `core_rdy` out 1: byte-strobe acknowledge, to `uio_in[1]`.
- `core_din` out 8: byte to core, to `ui_in`.
- `core_rq` in 1: byte request, from `uio_out[2]`.
- `core_done` in 1: output phase flag, from `uio_out[3]`.
- `core_dout` in 8: hash byte, from `uo_out`.

## Operation
- Storage: 76×8 prefix buffer, 32-bit nonce register, 8-bit difficulty.
- Reset values: all outputs 0, nonce 0, difficulty 0, prefix contents don't-care.
- `core_rq` and `core_done` are synchronised through 2 flops. A request event is a rising edge of synchronised rq.
- FSM states: IDLE, START, FEED, DRAIN, CHECK.
  - IDLE: on `go` → START. Clears `found`/`exhausted`, byte index=0, stop_pend=0.
  - START: `core_start`=1 for exactly 2 cycles → FEED.
  - FEED: on each rq event, index<76 → `core_din`=prefix[index]; index 76..79 → nonce byte (index−76), MSB first. Then index++. After byte 79 → DRAIN.
  - A request event seen in FEED with sync `core_done`=1 is a protocol error: go to DRAIN and treat it as a hash byte.
  - DRAIN: on each rq event, capture `core_dout` into the scorer and acknowledge. After 32 bytes, wait for sync `core_done`=0 → CHECK.
  - CHECK (1 cycle):
    - pass → `found`=1, `found_nonce`=nonce, → IDLE.
    - else nonce==0xFFFFFFFF → `exhausted`=1, → IDLE.
    - else nonce++, then → IDLE if stop_pend, otherwise → START.
- Acknowledge rule: for every rq event, `core_rdy`=1 for exactly one cycle. `core_din` is updated in that same cycle and held until the next event.
- Scorer (9-bit `lz`, flag `zrun`=1 at START):
  - byte==0 with zrun → lz+=8.
  - nonzero byte with zrun → lz+=clz8(byte), zrun=0.
  - zrun=0 → no change.
  - pass ⇔ lz ≥ difficulty. Difficulty 0 always passes; 256 zero bits gives lz=256.
- `stop` is latched into stop_pend in any non-IDLE state. It never aborts mid-attempt, because the core has no abort.
- Config write to a nonce address sets the start nonce directly. Nonce after a hit is not advanced: the next `go` re-tests the same nonce unless it is rewritten.

## Timing
- rq rising at core → `core_rdy` high 3 cycles later: 2 sync plus 1 registered. Pulse width is 1 cycle.
- `go` → `core_start` high on cycle +1 and +2.
- Per attempt overhead outside the core: 2 (START) + 1 (CHECK) + 3 (done sync) cycles.
- `found`/`exhausted`/`busy` update on the same edge that leaves CHECK; `busy` falls with it.
- Reset mid-attempt: FSM→IDLE, `core_start`/`core_rdy` drop immediately (async). The core must be reset alongside.
- `go` and `stop` in the same cycle while idle: the search starts with stop_pend=1 and runs exactly one attempt.

## Test plan
- Core model returns hash bytes {00,00,1F,…}, difficulty=19, start nonce 0x1DAC2B7C, prefix = the 76 genesis bytes (01 00 00 … 29 AB 5F 49 FF FF 00 1D). Required: model receives the 80 bytes in order, ending 1D AC 2B 7C; `found`=1; `found_nonce`=0x1DAC2B7C; `busy`=0 after one attempt.
- Same setup with difficulty=20 and the model returning 00 00 1F… for the first attempt, then 00 00 0F… for the second. Required: two attempts, `found_nonce`=0x1DAC2B7D.
- Start nonce 0xFFFFFFFE, model always returns FF…, difficulty=1. Required: two attempts, `exhausted`=1, `found`=0, nonce wraps to 0.
- `stop` pulsed during the FEED of attempt 1, failing hashes. Required: attempt 1 completes all 80+32 bytes, no START follows, `busy`=0, `found`=0.
- `cfg_we` to addr 80 with data 0x05 while `busy`. Required: difficulty unchanged. Also: each rq edge yields exactly one `core_rdy` pulse, 3 cycles after the edge.
- `rst_n` low during DRAIN. Required: all outputs 0 asynchronously; a fresh `go` after release runs a complete attempt.

Source files
------------

// File: rtl/btc_job_ctrl.sv
// btc_job_ctrl: job sequencer in front of the byte-serial hashing core.
// Holds a header prefix, start nonce and difficulty, repeatedly runs the
// core over prefix+nonce, scores each hash by leading zero bits and stops
// on a hit, on nonce exhaustion or after a host stop request.
module btc_job_ctrl #(
    parameter int HDR_BYTES  = 76,
    parameter int HASH_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [6:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic        go,
    input  logic        stop,
    output logic        busy,
    output logic        found,
    output logic        exhausted,
    output logic [31:0] found_nonce,
    output logic        core_start,
    output logic        core_rdy,
    output logic [7:0]  core_din,
    input  logic        core_rq,
    input  logic        core_done,
    input  logic [7:0]  core_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_DRAIN,
        S_CHECK
    } state_t;

    localparam logic [6:0] LAST_FEED = 7'(HDR_BYTES + 3);
    localparam logic [6:0] DIFF_ADDR = 7'(HDR_BYTES + 4);
    localparam logic [5:0] HASH_CNT  = 6'(HASH_BYTES);

    state_t      state;
    logic [7:0]  prefix [0:HDR_BYTES-1];
    logic [31:0] nonce;
    logic [7:0]  difficulty;

    logic        rq_s1, rq_s2, rq_s3;
    logic        done_s1, done_s2;
    logic        rq_event;

    logic [6:0]  idx;
    logic [5:0]  dcnt;
    logic        start_cnt;
    logic        stop_pend;

    logic [8:0]  lz;
    logic        zrun;
    logic [8:0]  lz_next;
    logic        zrun_next;
    logic [7:0]  feed_byte;
    logic        pass;

    // Count of leading zero bits in one byte; 8 for a zero byte.
    function automatic logic [3:0] clz8(input logic [7:0] b);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) n = 4'(7 - i);
        end
        return n;
    endfunction

    // Bring the core's rq/done flags into our clock domain; the extra rq
    // stage gives a clean rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_s1   <= 1'b0;
            rq_s2   <= 1'b0;
            rq_s3   <= 1'b0;
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
        end else begin
            rq_s1   <= core_rq;
            rq_s2   <= rq_s1;
            rq_s3   <= rq_s2;
            done_s1 <= core_done;
            done_s2 <= done_s1;
        end
    end

    assign rq_event = rq_s2 & ~rq_s3;

    // Prefix buffer is write-only from the host side and only while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy && (cfg_addr < 7'(HDR_BYTES))) begin
            prefix[cfg_addr] <= cfg_data;
        end
    end

    // Difficulty register, frozen while a search is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            difficulty <= 8'h00;
        end else if (cfg_we && !busy && (cfg_addr == DIFF_ADDR)) begin
            difficulty <= cfg_data;
        end
    end

    // Next byte to hand the core: prefix first, then the nonce MSB first.
    always_comb begin
        feed_byte = 8'h00;
        if (idx < 7'(HDR_BYTES)) begin
            feed_byte = prefix[idx];
        end else if (idx == 7'(HDR_BYTES)) begin
            feed_byte = nonce[31:24];
        end else if (idx == 7'(HDR_BYTES + 1)) begin
            feed_byte = nonce[23:16];
        end else if (idx == 7'(HDR_BYTES + 2)) begin
            feed_byte = nonce[15:8];
        end else begin
            feed_byte = nonce[7:0];
        end
    end

    // Leading-zero scorer update for the hash byte currently on core_dout.
    always_comb begin
        lz_next   = lz;
        zrun_next = zrun;
        if (zrun) begin
            if (core_dout == 8'h00) begin
                lz_next = lz + 9'd8;
            end else begin
                lz_next   = lz + {5'd0, clz8(core_dout)};
                zrun_next = 1'b0;
            end
        end
    end

    assign pass = (lz >= {1'b0, difficulty});

    // Main sequencer: start pulse, byte feed, hash drain and result check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_nonce <= 32'h0;
            core_start  <= 1'b0;
            core_rdy    <= 1'b0;
            core_din    <= 8'h00;
            nonce       <= 32'h0;
            idx         <= 7'd0;
            dcnt        <= 6'd0;
            start_cnt   <= 1'b0;
            stop_pend   <= 1'b0;
            lz          <= 9'd0;
            zrun        <= 1'b1;
        end else begin
            core_rdy <= 1'b0;
            if ((state != S_IDLE) && stop) stop_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        if (cfg_addr == 7'(HDR_BYTES))     nonce[31:24] <= cfg_data;
                        if (cfg_addr == 7'(HDR_BYTES + 1)) nonce[23:16] <= cfg_data;
                        if (cfg_addr == 7'(HDR_BYTES + 2)) nonce[15:8]  <= cfg_data;
                        if (cfg_addr == 7'(HDR_BYTES + 3)) nonce[7:0]   <= cfg_data;
                    end
                    if (go) begin
                        state      <= S_START;
                        busy       <= 1'b1;
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        stop_pend  <= stop;
                        core_start <= 1'b1;
                        start_cnt  <= 1'b0;
                        idx        <= 7'd0;
                        dcnt       <= 6'd0;
                        lz         <= 9'd0;
                        zrun       <= 1'b1;
                    end
                end

                S_START: begin
                    if (start_cnt) begin
                        core_start <= 1'b0;
                        state      <= S_FEED;
                    end else begin
                        start_cnt <= 1'b1;
                    end
                end

                S_FEED: begin
                    if (rq_event) begin
                        core_rdy <= 1'b1;
                        if (done_s2) begin
                            lz    <= lz_next;
                            zrun  <= zrun_next;
                            dcnt  <= 6'd1;
                            state <= S_DRAIN;
                        end else begin
                            core_din <= feed_byte;
                            idx      <= idx + 7'd1;
                            if (idx == LAST_FEED) begin
                                dcnt  <= 6'd0;
                                state <= S_DRAIN;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    if (dcnt == HASH_CNT) begin
                        if (!done_s2) state <= S_CHECK;
                    end else if (rq_event) begin
                        core_rdy <= 1'b1;
                        lz       <= lz_next;
                        zrun     <= zrun_next;
                        dcnt     <= dcnt + 6'd1;
                    end
                end

                S_CHECK: begin
                    if (pass) begin
                        found       <= 1'b1;
                        found_nonce <= nonce;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        nonce <= nonce + 32'd1;
                        if (nonce == 32'hFFFF_FFFF) begin
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else if (stop_pend || stop) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            core_start <= 1'b1;
                            start_cnt  <= 1'b0;
                            idx        <= 7'd0;
                            dcnt       <= 6'd0;
                            lz         <= 9'd0;
                            zrun       <= 1'b1;
                            state      <= S_START;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btc_job_ctrl.sv
// tb_btc_job_ctrl: scoreboard bench with a behavioural model of the hashing
// core's rq/rdy byte protocol.
module tb_btc_job_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [6:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        go;
    logic        stop;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic [31:0] found_nonce;
    logic        core_start;
    logic        core_rdy;
    logic [7:0]  core_din;
    logic        core_rq;
    logic        core_done;
    logic [7:0]  core_dout;

    int checks = 0;
    int errors = 0;

    logic [607:0] gen_hdr;
    logic [7:0]   exp_q[$];
    logic [7:0]   third_q[$];
    bit           all_ff;

    int          m_phase;
    int          m_cnt;
    int          m_gap;
    int          m_wait;
    bit          m_req;
    bit          m_start_prev;
    logic [7:0]  m_third;
    int          m_attempts = 0;
    int          m_starts   = 0;
    int          m_fed      = 0;

    btc_job_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .go         (go),
        .stop       (stop),
        .busy       (busy),
        .found      (found),
        .exhausted  (exhausted),
        .found_nonce(found_nonce),
        .core_start (core_start),
        .core_rdy   (core_rdy),
        .core_din   (core_din),
        .core_rq    (core_rq),
        .core_done  (core_done),
        .core_dout  (core_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hash byte k of the current attempt as the core model returns it.
    function automatic logic [7:0] hash_byte(input int k);
        if (all_ff) return 8'hFF;
        if (k < 2) return 8'h00;
        if (k == 2) return m_third;
        return 8'hA5;
    endfunction

    // Core model: answers core_start, requests 80 bytes, then offers 32
    // hash bytes; checks every fed byte and the rdy latency and width.
    initial begin : core_model
        core_rq = 1'b0; core_done = 1'b0; core_dout = 8'h00;
        m_phase = 0; m_cnt = 0; m_gap = 0; m_wait = 0; m_req = 1'b0;
        m_start_prev = 1'b0; m_third = 8'hFF;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                core_rq = 1'b0; core_done = 1'b0; core_dout = 8'h00;
                m_phase = 0; m_req = 1'b0; m_gap = 0; m_start_prev = 1'b0;
            end else begin
                if (core_start) begin
                    if (!m_start_prev) m_starts++;
                    m_phase = 1; m_cnt = 0; m_gap = 2; m_req = 1'b0;
                    core_rq = 1'b0; core_done = 1'b0;
                end else if (m_phase != 0) begin
                    if (m_req) begin
                        m_wait++;
                        if (core_rdy) begin
                            checks++;
                            if (m_wait != 3) begin
                                errors++;
                                $display("[TB] FAIL rdy_latency: got %0d cycles, expected 3", m_wait);
                            end
                            if (m_phase == 1) begin
                                checks++;
                                if (exp_q.size() == 0) begin
                                    errors++;
                                    $display("[TB] FAIL feed_byte: got %h at byte %0d, expected none", core_din, m_cnt);
                                end else begin
                                    logic [7:0] e;
                                    e = exp_q.pop_front();
                                    if (core_din !== e) begin
                                        errors++;
                                        $display("[TB] FAIL feed_byte: got %h at byte %0d, expected %h", core_din, m_cnt, e);
                                    end
                                end
                                m_fed++;
                                m_cnt++;
                                if (m_cnt == 80) begin
                                    m_phase = 2; m_cnt = 0; core_done = 1'b1;
                                    m_third = (third_q.size() != 0) ? third_q.pop_front() : 8'hFF;
                                end
                            end else begin
                                m_cnt++;
                                if (m_cnt == 32) begin
                                    core_done = 1'b0; m_phase = 0; m_attempts++;
                                end
                            end
                            core_rq = 1'b0; m_req = 1'b0; m_gap = 3;
                        end else if (m_wait > 8) begin
                            checks++; errors++;
                            $display("[TB] FAIL rdy_timeout: got no rdy after %0d cycles, expected 3", m_wait);
                            core_rq = 1'b0; m_req = 1'b0; m_phase = 0;
                        end
                    end else begin
                        if (core_rdy) begin
                            checks++; errors++;
                            $display("[TB] FAIL spurious_rdy: got rdy=1 without request, expected 0");
                        end
                        if (m_gap > 0) m_gap--;
                        if (m_gap == 0) begin
                            if (m_phase == 2) core_dout = hash_byte(m_cnt);
                            core_rq = 1'b1; m_req = 1'b1; m_wait = 0;
                        end
                    end
                end else if (core_rdy) begin
                    checks++; errors++;
                    $display("[TB] FAIL spurious_rdy: got rdy=1 while core idle, expected 0");
                end
                m_start_prev = core_start;
            end
        end
    end

    task automatic cfg_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_genesis();
        for (int i = 0; i < 76; i++) cfg_write(7'(i), gen_hdr[607-8*i -: 8]);
    endtask

    task automatic set_nonce(input logic [31:0] n);
        cfg_write(7'd76, n[31:24]);
        cfg_write(7'd77, n[23:16]);
        cfg_write(7'd78, n[15:8]);
        cfg_write(7'd79, n[7:0]);
    endtask

    task automatic push_attempt(input logic [31:0] n);
        for (int i = 0; i < 76; i++) exp_q.push_back(gen_hdr[607-8*i -: 8]);
        exp_q.push_back(n[31:24]);
        exp_q.push_back(n[23:16]);
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
    endtask

    task automatic pulse_go(input bit with_stop);
        @(negedge clk);
        go = 1'b1; stop = with_stop;
        @(negedge clk);
        go = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, found, exhausted, core_start, core_rdy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000", {busy, found, exhausted, core_start, core_rdy});
        end
        checks++;
        if (found_nonce !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_found_nonce: got %h, expected 00000000", found_nonce);
        end
        checks++;
        if (core_din !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_core_din: got %h, expected 00", core_din);
        end
    endtask

    task automatic test_genesis_hit();
        bit to;
        int a0;
        load_genesis();
        set_nonce(32'h1DAC2B7C);
        cfg_write(7'd80, 8'd19);
        all_ff = 1'b0;
        third_q.push_back(8'h1F);
        push_attempt(32'h1DAC2B7C);
        a0 = m_attempts;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++;
        if ({busy, core_start} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL start_cycle1: got busy,start=%b, expected 11", {busy, core_start});
        end
        @(negedge clk);
        checks++;
        if (core_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_cycle2: got %b, expected 1", core_start);
        end
        @(negedge clk);
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_cycle3: got %b, expected 0", core_start);
        end
        wait_idle(5000, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL genesis_timeout: got busy=1, expected 0");
        end
        checks++;
        if ({found, exhausted} !== 2'b10 || found_nonce !== 32'h1DAC2B7C) begin
            errors++;
            $display("[TB] FAIL genesis_result: got found=%b exh=%b nonce=%h, expected 1 0 1dac2b7c", found, exhausted, found_nonce);
        end
        checks++;
        if (m_attempts - a0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL genesis_attempts: got %0d attempts, %0d bytes left, expected 1, 0", m_attempts - a0, exp_q.size());
        end
    endtask

    task automatic test_second_nonce();
        bit to;
        int a0;
        cfg_write(7'd80, 8'd20);
        all_ff = 1'b0;
        third_q.push_back(8'h1F);
        third_q.push_back(8'h0F);
        push_attempt(32'h1DAC2B7C);
        push_attempt(32'h1DAC2B7D);
        a0 = m_attempts;
        pulse_go(1'b0);
        wait_idle(5000, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL second_timeout: got busy=1, expected 0");
        end
        checks++;
        if (found !== 1'b1 || found_nonce !== 32'h1DAC2B7D) begin
            errors++;
            $display("[TB] FAIL second_result: got found=%b nonce=%h, expected 1 1dac2b7d", found, found_nonce);
        end
        checks++;
        if (m_attempts - a0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL second_attempts: got %0d attempts, %0d bytes left, expected 2, 0", m_attempts - a0, exp_q.size());
        end
    endtask

    task automatic test_exhaust();
        bit to;
        int a0;
        set_nonce(32'hFFFFFFFE);
        cfg_write(7'd80, 8'd1);
        all_ff = 1'b1;
        push_attempt(32'hFFFFFFFE);
        push_attempt(32'hFFFFFFFF);
        a0 = m_attempts;
        pulse_go(1'b0);
        wait_idle(5000, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL exhaust_timeout: got busy=1, expected 0");
        end
        checks++;
        if ({found, exhausted} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL exhaust_flags: got found=%b exh=%b, expected 0 1", found, exhausted);
        end
        checks++;
        if (m_attempts - a0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL exhaust_attempts: got %0d attempts, %0d bytes left, expected 2, 0", m_attempts - a0, exp_q.size());
        end
    endtask

    task automatic test_go_stop_same_cycle();
        bit to;
        int a0;
        all_ff = 1'b1;
        push_attempt(32'h00000000);
        a0 = m_attempts;
        pulse_go(1'b1);
        wait_idle(5000, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL gostop_timeout: got busy=1, expected 0");
        end
        checks++;
        if ({found, exhausted} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL gostop_flags: got found=%b exh=%b, expected 0 0", found, exhausted);
        end
        checks++;
        if (m_attempts - a0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL gostop_attempts: got %0d attempts, %0d bytes left, expected 1, 0", m_attempts - a0, exp_q.size());
        end
    endtask

    task automatic test_stop_mid();
        bit to;
        int a0, s0, f0;
        bit reached;
        set_nonce(32'h00000100);
        cfg_write(7'd80, 8'd1);
        all_ff = 1'b1;
        push_attempt(32'h00000100);
        a0 = m_attempts; s0 = m_starts; f0 = m_fed;
        pulse_go(1'b0);
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (m_fed - f0 >= 10) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("[TB] FAIL stop_feed_timeout: got %0d bytes, expected 10", m_fed - f0);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(5000, to);
        checks++;
        if (to || busy !== 1'b0 || found !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_result: got busy=%b found=%b, expected 0 0", busy, found);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (m_attempts - a0 != 1 || m_starts - s0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL stop_attempts: got %0d attempts %0d starts, expected 1 1", m_attempts - a0, m_starts - s0);
        end
    endtask

    task automatic test_cfg_while_busy();
        bit to;
        int a0;
        set_nonce(32'h1DAC2B7C);
        cfg_write(7'd80, 8'd20);
        all_ff = 1'b0;
        third_q.push_back(8'h1F);
        third_q.push_back(8'h0F);
        push_attempt(32'h1DAC2B7C);
        push_attempt(32'h1DAC2B7D);
        a0 = m_attempts;
        pulse_go(1'b0);
        cfg_write(7'd80, 8'h05);
        cfg_write(7'd79, 8'h00);
        wait_idle(5000, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL busycfg_timeout: got busy=1, expected 0");
        end
        checks++;
        if (found !== 1'b1 || found_nonce !== 32'h1DAC2B7D) begin
            errors++;
            $display("[TB] FAIL busycfg_result: got found=%b nonce=%h, expected 1 1dac2b7d", found, found_nonce);
        end
        checks++;
        if (m_attempts - a0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL busycfg_attempts: got %0d attempts, %0d bytes left, expected 2, 0", m_attempts - a0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit reached;
        int a0;
        set_nonce(32'h00000200);
        cfg_write(7'd80, 8'd1);
        all_ff = 1'b1;
        push_attempt(32'h00000200);
        pulse_go(1'b0);
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (m_phase == 2 && m_cnt >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("[TB] FAIL rstmid_drain_timeout: got phase %0d, expected 2", m_phase);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, found, exhausted, core_start, core_rdy} !== 5'b0 || core_din !== 8'h00 || found_nonce !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got flags=%b din=%h nonce=%h, expected 0", {busy, found, exhausted, core_start, core_rdy}, core_din, found_nonce);
        end
        exp_q.delete();
        third_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        load_genesis();
        push_attempt(32'h00000000);
        a0 = m_attempts;
        pulse_go(1'b0);
        wait_idle(5000, to);
        checks++;
        if (to || found !== 1'b1 || found_nonce !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_rerun: got found=%b nonce=%h, expected 1 00000000", found, found_nonce);
        end
        checks++;
        if (m_attempts - a0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_attempts: got %0d attempts, %0d bytes left, expected 1, 0", m_attempts - a0, exp_q.size());
        end
    endtask

    // Global guard so the run always terminates.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        gen_hdr = {32'h01000000,
                   256'h0,
                   64'h3ba3edfd_7a7b12b2, 64'h7ac72c3e_67768f61,
                   64'h7fc81bc3_888a5132, 64'h3a9fb8aa_4b1e5e4a,
                   64'h29ab5f49_ffff001d};
        all_ff = 1'b1;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 7'd0; cfg_data = 8'h00;
        go = 1'b0; stop = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] starting btc_job_ctrl tests");
        test_reset();
        test_genesis_hit();
        test_second_nonce();
        test_exhaust();
        test_go_stop_same_cycle();
        test_stop_mid();
        test_cfg_while_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
